out_capture_tx: RTL and testbench
=================================

# out_capture_tx

Output capture and serial transmit stage sitting directly downstream of `SimpleProcessor`; its `data_in` is driven by the processor's `data_out`. It samples the processor result bus every clock and queues changed values (or every value) in a small FIFO. It then serializes them as 8N1 frames on a single `tx` line, so results leave the design on one pin instead of through a simulator monitor.

## Interface
- `CLKS_PER_BIT`, 4, clock cycles per serial bit; legal range ≥ 2.
- `FIFO_DEPTH`, 8, capture FIFO entries; must be a power of 2, ≥ 2.
- `CAPTURE_ALL`, 0, 0 = push only on value change; 1 = push every enabled cycle.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `data_in`  in  8  processor result bus, sampled every rising edge.
- `en`  in  1  capture enable; when 0, no sampling and no push.
- `tx`  out  1  serial line, idle high, LSB first.
- `busy`  out  1  high while a frame is in progress.
- `overflow`  out  1  sticky; set when a push is dropped; cleared only by reset.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- Reset (`rst`=0) forces `tx`=1, `busy`=0, `overflow`=0, `fifo_count`=0, FSM=IDLE, and FIFO pointers=0. It also clears the `have_last` flag. All of this takes effect asynchronously.
- Capture (`en`=1, per edge):
  - `CAPTURE_ALL`=0: push request when `!have_last` or `data_in != last`.
  - `last` is loaded with `data_in` on every enabled edge.
  - `have_last` is set to 1 on every enabled edge.
- Push acceptance:
  - Accepted if `fifo_count < FIFO_DEPTH`.
  - Also accepted when the FIFO is full but a pop occurs the same edge; `fifo_count` is unchanged in that case.
  - Otherwise the data is dropped and `overflow` is set to 1.
- Pointers are `$clog2(FIFO_DEPTH)` bits and wrap modulo `FIFO_DEPTH`.
- TX FSM states:
  - IDLE: `tx`=1. If `fifo_count` ≠ 0, pop the head into `shift[7:0]`, clear the bit counter, and go to START.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA: `tx`=`shift[0]`. Shift right every `CLKS_PER_BIT` cycles; after 8 bits go to STOP.
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles. On the last STOP cycle:
    - if the FIFO is non-empty, pop and go to START (back-to-back frames);
    - otherwise go to IDLE.
- `busy` = (state ≠ IDLE), registered with the state.
- Baud counter: counts 0…`CLKS_PER_BIT`−1 and resets to 0 on every state transition.

## Timing
- `tx` and `busy` are registered outputs; `fifo_count` is registered.
- Capture latency: a value sampled at edge k is counted in `fifo_count` after edge k.
- Start latency: with the FSM in IDLE and the FIFO empty before edge k, the value is popped at edge k+1. `tx` goes low after edge k+1.
- Frame length: exactly 10·`CLKS_PER_BIT` cycles.
- Back-to-back frames have zero idle cycles between the stop bit and the next start bit.
- Simultaneous push and pop on an empty FIFO: not possible, since the pop requires `fifo_count` ≠ 0 before the edge. The push lands and is popped on a later edge.
- Reset mid-frame: `tx` returns to 1 immediately. No partial frame resumes after release, and queued data is discarded.
- `en` deassert mid-frame does not affect transmission of already-queued data.

## Structure
- Package `out_capture_pkg`:
  - `tx_state_t` enum {IDLE, START, DATA, STOP};
  - `FRAME_BITS` = 10;
  - `TX_IDLE_LEVEL` = 1'b1.
- Sub-module `sync_fifo`:
  - parameters `WIDTH`, `DEPTH`;
  - ports `clk`, `rst` (async active-low), `push`, `push_data`, `pop`, `pop_data`, `count`, `full`, `empty`.
  - `pop_data` is the combinational head.
- Top contains the change detector, overflow flag, and TX FSM.

## Test plan
1. Reset: hold `rst`=0 with random `data_in` → `tx`=1, `busy`=0, `overflow`=0, `fifo_count`=0. Deassert mid-frame → `tx`=1 within the same cycle, and no frame follows.
2. Single frame, `CLKS_PER_BIT`=4: `data_in`=8'hA5 for 1 cycle, then hold → `tx` sequence is 0, then 1,0,1,0,0,1,0,1, then 1, each bit 4 cycles. `busy` is high for exactly 40 cycles.
3. Change detect, `CAPTURE_ALL`=0: hold 8'h3C for 100 cycles → exactly one frame. Step to 8'h3D → exactly one more frame, carrying 8'h3D.
4. Overflow, `CAPTURE_ALL`=1, depth 8: `data_in`=$time ramp for 20 cycles → `fifo_count` reaches 8 and `overflow`=1. The first 9 captured bytes are transmitted in order, and later bytes are dropped.
5. Back-to-back: push 8'h01 and 8'h80 on consecutive cycles → the second start bit begins the cycle after the first stop bit ends. Total `busy` time is 80 cycles with no gap.
6. Enable gating: `en`=0 while `data_in` toggles → `fifo_count` stays 0 and `tx` stays 1. Re-enable → the first sample is pushed even if its value equals the pre-gating value.

Source files
------------

// File: rtl/out_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module   : out_capture_pkg
// Purpose  : Shared types and constants for the output capture / serial
//            transmit stage.
// Contents : tx_state_t    - transmitter FSM state encoding
//            FRAME_BITS    - bits per 8N1 frame (start + 8 data + stop)
//            DATA_BITS     - data bits per frame
//            TX_IDLE_LEVEL - line level while idle / during stop bit
// Revision : 1.0 - initial release
// ============================================================================
package out_capture_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int   FRAME_BITS    = 10;
  localparam int   DATA_BITS     = FRAME_BITS - 2;
  localparam logic TX_IDLE_LEVEL = 1'b1;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock FIFO with a combinational head. A push into a full
//            FIFO is accepted when a pop happens on the same edge.
// Ports    : clk       - clock, rising edge
//            rst       - asynchronous active-low reset (pointers/count only)
//            push      - write request
//            push_data - write data
//            pop       - read request (ignored when empty)
//            pop_data  - current head entry (combinational)
//            count     - occupancy, 0..DEPTH
//            full      - count == DEPTH
//            empty     - count == 0
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  // When full, the slot being written is the one being popped this edge;
  // the popped value has already been consumed from the combinational head.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      count_d = count_q + (AW+1)'(1);
    else if (!do_push && do_pop) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset: entries are only visible through count/pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/out_capture_tx.sv
`default_nettype none
// ============================================================================
// Module   : out_capture_tx
// Purpose  : Samples the processor result bus, queues changed (or all)
//            values in a FIFO and transmits them as 8N1 frames, LSB first.
// Ports    : clk        - clock, rising edge
//            rst        - asynchronous active-low reset
//            data_in    - processor result bus
//            en         - capture enable
//            tx         - serial line, idle high (registered)
//            busy       - frame in progress (registered)
//            overflow   - sticky dropped-push flag
//            fifo_count - FIFO occupancy (registered)
// Revision : 1.0 - initial release
// ============================================================================
module out_capture_tx
  import out_capture_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 8,
  parameter int CAPTURE_ALL  = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    data_in,
  input  logic                          en,
  output logic                          tx,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int            BW        = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);

  tx_state_t    state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]   bit_q, bit_d;
  logic [7:0]   shift_q, shift_d;
  logic         tx_q, tx_d;
  logic         busy_q, busy_d;
  logic         overflow_q, overflow_d;
  logic [7:0]   last_q, last_d;
  logic         have_last_q, have_last_d;

  logic         push_req, pop;
  logic [7:0]   head;
  logic         fifo_full, fifo_empty;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_req),
    .push_data (data_in),
    .pop       (pop),
    .pop_data  (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Change detector. A disabled edge breaks the sample history, so the first
  // sample after re-enabling is always pushed.
  always_comb begin
    push_req    = 1'b0;
    last_d      = last_q;
    have_last_d = 1'b0;
    if (en) begin
      push_req    = (CAPTURE_ALL != 0) || !have_last_q || (data_in != last_q);
      last_d      = data_in;
      have_last_d = 1'b1;
    end
    overflow_d = overflow_q | (push_req & fifo_full & ~pop);
  end

  // Transmit FSM. tx/busy are derived from the next state so they are
  // registered together with it.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = head;
          bit_d   = '0;
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == BIT_LAST) state_d = STOP;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      STOP: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = head;
            bit_d   = '0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = TX_IDLE_LEVEL;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      baud_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      tx_q        <= TX_IDLE_LEVEL;
      busy_q      <= 1'b0;
      overflow_q  <= 1'b0;
      last_q      <= '0;
      have_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      overflow_q  <= overflow_d;
      last_q      <= last_d;
      have_last_q <= have_last_d;
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_out_capture_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_out_capture_tx
// Purpose  : Directed self-checking bench for out_capture_tx. Two instances:
//            dut (change-detect capture) and dut_all (capture every cycle).
//            Inputs change and outputs are sampled on the falling clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_out_capture_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] data0 = 8'h00, data1 = 8'h00;
  logic       en0 = 1'b0, en1 = 1'b0;
  logic       tx0, busy0, ovf0, tx1, busy1, ovf1;
  logic [3:0] cnt0, cnt1;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  out_capture_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(8), .CAPTURE_ALL(0)) dut (
    .clk(clk), .rst(rst), .data_in(data0), .en(en0),
    .tx(tx0), .busy(busy0), .overflow(ovf0), .fifo_count(cnt0)
  );

  out_capture_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(8), .CAPTURE_ALL(1)) dut_all (
    .clk(clk), .rst(rst), .data_in(data1), .en(en1),
    .tx(tx1), .busy(busy1), .overflow(ovf1), .fifo_count(cnt1)
  );

  // Waits (bounded) for a start bit, then records 40 consecutive cycles of
  // the line. Returns on the negedge of the last stop-bit cycle.
  task automatic rx_frame(input bit sel, input int budget, output logic [7:0] data,
                          output int waited, output bit found, output bit framing_ok,
                          output int busy_hi);
    logic [39:0] s;
    data = 8'h00; waited = 0; found = 1'b0; framing_ok = 1'b1; busy_hi = 0; s = '0;
    while (((sel ? tx1 : tx0) !== 1'b0) && (waited < budget)) begin
      @(negedge clk);
      waited++;
    end
    if ((sel ? tx1 : tx0) !== 1'b0) return;
    found = 1'b1;
    for (int j = 0; j < 40; j++) begin
      if (j != 0) @(negedge clk);
      s[j] = sel ? tx1 : tx0;
      if ((sel ? busy1 : busy0) === 1'b1) busy_hi++;
    end
    for (int b = 0; b < 10; b++)
      for (int k = 1; k < 4; k++)
        if (s[4*b+k] !== s[4*b]) framing_ok = 1'b0;
    if (s[0] !== 1'b0 || s[36] !== 1'b1) framing_ok = 1'b0;
    for (int i = 0; i < 8; i++) data[i] = s[4 + 4*i];
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      data0 = 8'($urandom); data1 = 8'($urandom); en0 = 1'b1; en1 = 1'b1;
    end
    checks++; if (tx0 !== 1'b1)   begin errors++; $display("FAIL reset_tx: got %b expected 1", tx0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy0); end
    checks++; if (ovf0 !== 1'b0)  begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf0); end
    checks++; if (cnt0 !== 4'd0)  begin errors++; $display("FAIL reset_count: got %0d expected 0", cnt0); end
    checks++; if (tx1 !== 1'b1)   begin errors++; $display("FAIL reset_tx_all: got %b expected 1", tx1); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy_all: got %b expected 0", busy1); end
    checks++; if (ovf1 !== 1'b0)  begin errors++; $display("FAIL reset_ovf_all: got %b expected 0", ovf1); end
    checks++; if (cnt1 !== 4'd0)  begin errors++; $display("FAIL reset_count_all: got %0d expected 0", cnt1); end
    en0 = 1'b0; en1 = 1'b0;
    @(negedge clk); rst = 1'b1;
    // Start a frame, then reset in the middle of it.
    data0 = 8'h55; en0 = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL midframe_busy: got %b expected 1", busy0); end
    #2 rst = 1'b0;
    #1;
    checks++; if (tx0 !== 1'b1)   begin errors++; $display("FAIL midreset_tx: got %b expected 1", tx0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", busy0); end
    checks++; if (cnt0 !== 4'd0)  begin errors++; $display("FAIL midreset_count: got %0d expected 0", cnt0); end
    en0 = 1'b0;
    @(negedge clk); rst = 1'b1;
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx0 !== 1'b1 || busy0 !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL no_resume: got %0d active cycles expected 0", bad); end
  endtask

  task automatic test_single_frame();
    logic [7:0] d; int w, bh; bit f, fo;
    @(negedge clk); data0 = 8'hA5; en0 = 1'b1;
    @(negedge clk);
    checks++; if (cnt0 !== 4'd1) begin errors++; $display("FAIL capture_latency: got %0d expected 1", cnt0); end
    checks++; if (tx0 !== 1'b1)  begin errors++; $display("FAIL pre_start_tx: got %b expected 1", tx0); end
    @(negedge clk);
    checks++; if (tx0 !== 1'b0)  begin errors++; $display("FAIL start_latency: got %b expected 0", tx0); end
    rx_frame(1'b0, 5, d, w, f, fo, bh);
    checks++; if (f !== 1'b1 || d !== 8'hA5) begin errors++; $display("FAIL single_data: got %h found %b expected a5", d, f); end
    checks++; if (fo !== 1'b1) begin errors++; $display("FAIL single_framing: got %b expected 1", fo); end
    checks++; if (bh != 40)    begin errors++; $display("FAIL single_busy_len: got %0d expected 40", bh); end
    @(negedge clk);
    checks++; if (busy0 !== 1'b0 || tx0 !== 1'b1) begin errors++; $display("FAIL single_end: got busy %b tx %b expected 0 1", busy0, tx0); end
  endtask

  task automatic test_change_detect();
    logic [7:0] d; int w, bh, lows; bit f, fo;
    data0 = 8'h3C;
    rx_frame(1'b0, 10, d, w, f, fo, bh);
    checks++; if (f !== 1'b1 || d !== 8'h3C || fo !== 1'b1) begin errors++; $display("FAIL change_first: got %h found %b framing %b expected 3c", d, f, fo); end
    lows = 0;
    repeat (55) begin @(negedge clk); if (tx0 !== 1'b1) lows++; end
    checks++; if (lows != 0) begin errors++; $display("FAIL change_hold: got %0d low cycles expected 0", lows); end
    data0 = 8'h3D;
    rx_frame(1'b0, 10, d, w, f, fo, bh);
    checks++; if (f !== 1'b1 || d !== 8'h3D || fo !== 1'b1) begin errors++; $display("FAIL change_step: got %h found %b framing %b expected 3d", d, f, fo); end
    lows = 0;
    repeat (20) begin @(negedge clk); if (tx0 !== 1'b1) lows++; end
    checks++; if (lows != 0) begin errors++; $display("FAIL change_after_step: got %0d low cycles expected 0", lows); end
  endtask

  task automatic test_overflow();
    logic [7:0] got [9];
    bit         fnd [9];
    bit         fok [9];
    int         lows;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          data1 = 8'(8'h40 + i); en1 = 1'b1;
          @(negedge clk);
        end
        en1 = 1'b0;
        checks++; if (cnt1 !== 4'd8) begin errors++; $display("FAIL ovf_count: got %0d expected 8", cnt1); end
        checks++; if (ovf1 !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", ovf1); end
      end
      begin
        int w, bh;
        for (int i = 0; i < 9; i++) rx_frame(1'b1, 200, got[i], w, fnd[i], fok[i], bh);
      end
    join
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (fnd[i] !== 1'b1 || fok[i] !== 1'b1 || got[i] !== 8'(8'h40 + i)) begin
        errors++; $display("FAIL ovf_frame%0d: got %h found %b framing %b expected %h", i, got[i], fnd[i], fok[i], 8'(8'h40 + i));
      end
    end
    lows = 0;
    repeat (60) begin @(negedge clk); if (tx1 !== 1'b1) lows++; end
    checks++; if (lows != 0)     begin errors++; $display("FAIL ovf_dropped: got %0d low cycles expected 0", lows); end
    checks++; if (cnt1 !== 4'd0) begin errors++; $display("FAIL ovf_drain: got %0d expected 0", cnt1); end
    checks++; if (ovf0 !== 1'b0) begin errors++; $display("FAIL ovf_other: got %b expected 0", ovf0); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d1, d2; int w1, w2, bh1, bh2; bit f1, f2, fo1, fo2;
    @(negedge clk); data0 = 8'h01;
    @(negedge clk); data0 = 8'h80;
    rx_frame(1'b0, 10, d1, w1, f1, fo1, bh1);
    @(negedge clk);
    rx_frame(1'b0, 3, d2, w2, f2, fo2, bh2);
    checks++; if (f1 !== 1'b1 || d1 !== 8'h01 || fo1 !== 1'b1) begin errors++; $display("FAIL b2b_first: got %h found %b framing %b expected 01", d1, f1, fo1); end
    checks++; if (f2 !== 1'b1 || d2 !== 8'h80 || fo2 !== 1'b1) begin errors++; $display("FAIL b2b_second: got %h found %b framing %b expected 80", d2, f2, fo2); end
    checks++; if (w2 != 0) begin errors++; $display("FAIL b2b_gap: got %0d idle cycles expected 0", w2); end
    checks++; if (bh1 + bh2 != 80) begin errors++; $display("FAIL b2b_busy: got %0d expected 80", bh1 + bh2); end
    @(negedge clk);
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL b2b_end: got %b expected 0", busy0); end
  endtask

  task automatic test_enable_gating();
    logic [7:0] d; int w, bh, bad; bit f, fo;
    @(negedge clk); en0 = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      data0 = (i % 2 == 0) ? 8'h5A : 8'hC3;
      @(negedge clk);
      if (cnt0 !== 4'd0 || tx0 !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL gate_idle: got %0d active cycles expected 0", bad); end
    data0 = 8'h80; en0 = 1'b1;
    @(negedge clk);
    checks++; if (cnt0 !== 4'd1) begin errors++; $display("FAIL gate_reenable: got %0d expected 1", cnt0); end
    rx_frame(1'b0, 5, d, w, f, fo, bh);
    checks++; if (f !== 1'b1 || d !== 8'h80 || fo !== 1'b1) begin errors++; $display("FAIL gate_frame: got %h found %b framing %b expected 80", d, f, fo); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_change_detect();
    test_overflow();
    test_back_to_back();
    test_enable_gating();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
